// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Buffered immediate generator for the pipelined RV32I/RV64I datapath. Each
// accepted instruction has its immediate type chosen and its immediate
// sign-extended to XLEN in the same cycle. The result is written into a
// DEPTH-entry FIFO, so decode can run ahead of a stalled execute stage.
//
// Parameters:
//   XLEN        - datapath width, 32 or 64
//   DEPTH       - FIFO entries, power of two, >= 2
//   AUTO_DECODE - 0: type comes from ImmSrc; 1: type decoded from Inst[6:0]
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               synchronous clear of all queued entries (wins over push/pop)
//   in_valid/in_ready   input handshake carrying Inst and ImmSrc
//   Inst[31:0]          instruction word
//   ImmSrc[2:0]         immediate type select (ignored when AUTO_DECODE=1)
//   out_valid/out_ready output handshake for the head entry
//   ImmExt[XLEN-1:0]    head entry immediate
//   ImmType[2:0]        head entry type code (same encoding as ImmSrc)
//   count               number of occupied entries
//
// Optional feature (macro IMM_GEN_PIPE_ILLEGAL_EN):
//   illegal             head entry carried an invalid type (0 when out_valid=0)
//   illegal_seen        sticky, set by any push of an invalid type, cleared by rst
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its data stable while valid && !ready. ready never
// depends combinationally on valid. Both in_ready and out_valid come from
// registered state only.
//
// Type codes: 000 I, 001 S, 101 B, 010 U, 110 J; every other code is invalid.
// An invalid code yields immediate 0 and is passed through as ImmType.
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 2,
  parameter int AUTO_DECODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              Inst,
  input  logic [2:0]               ImmSrc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          ImmExt,
  output logic [2:0]               ImmType,
  output logic [$clog2(DEPTH):0]   count
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
  ,
  output logic                     illegal,
  output logic                     illegal_seen
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] TYPE_I   = 3'b000;
  localparam logic [2:0] TYPE_S   = 3'b001;
  localparam logic [2:0] TYPE_B   = 3'b101;
  localparam logic [2:0] TYPE_U   = 3'b010;
  localparam logic [2:0] TYPE_J   = 3'b110;
  localparam logic [2:0] TYPE_BAD = 3'b111;

  // ---------------------------------------------------------------------------
  // Input side: type selection and immediate formation (combinational)
  // ---------------------------------------------------------------------------
  logic [2:0]      type_sel;
  logic [31:0]     imm32;
  logic            type_valid;
  logic [XLEN-1:0] imm_ext;

  always_comb begin
    type_sel = ImmSrc;
    if (AUTO_DECODE != 0) begin
      case (Inst[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: type_sel = TYPE_I;
        7'b0100011:                                     type_sel = TYPE_S;
        7'b1100011:                                     type_sel = TYPE_B;
        7'b0110111, 7'b0010111:                         type_sel = TYPE_U;
        7'b1101111:                                     type_sel = TYPE_J;
        default:                                        type_sel = TYPE_BAD;
      endcase
    end
  end

  // Every format is first built as a 32-bit sign-extended value. The signed
  // cast below then widens it for XLEN=64. For XLEN=32 the cast is a no-op,
  // which is why U-type needs no separate extension path.
  always_comb begin
    imm32      = '0;
    type_valid = 1'b1;
    case (type_sel)
      TYPE_I:  imm32 = {{20{Inst[31]}}, Inst[31:20]};
      TYPE_S:  imm32 = {{20{Inst[31]}}, Inst[31:25], Inst[11:7]};
      TYPE_B:  imm32 = {{19{Inst[31]}}, Inst[31], Inst[7], Inst[30:25], Inst[11:8], 1'b0};
      TYPE_U:  imm32 = {Inst[31:12], 12'b0};
      TYPE_J:  imm32 = {{11{Inst[31]}}, Inst[31], Inst[19:12], Inst[20], Inst[30:21], 1'b0};
      default: type_valid = 1'b0;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] mem_imm_q  [DEPTH];
  logic [2:0]      mem_type_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  // Last head value seen while out_valid was high. It drives the outputs
  // while the FIFO is empty, so ImmExt/ImmType hold instead of showing a
  // stale storage slot.
  logic [XLEN-1:0] hold_imm_q, hold_imm_d;
  logic [2:0]      hold_type_q, hold_type_d;

  logic push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);

  // flush suppresses both transfers; the instruction offered in that cycle
  // is dropped.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    hold_imm_d  = hold_imm_q;
    hold_type_d = hold_type_q;

    if (out_valid) begin
      hold_imm_d  = mem_imm_q[rd_ptr_q];
      hold_type_d = mem_type_q[rd_ptr_q];
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_imm_q  <= '0;
      hold_type_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_imm_q[i]  <= '0;
        mem_type_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_imm_q  <= hold_imm_d;
      hold_type_q <= hold_type_d;
      if (push) begin
        mem_imm_q[wr_ptr_q]  <= imm_ext;
        mem_type_q[wr_ptr_q] <= type_sel;
      end
    end
  end

  assign ImmExt  = out_valid ? mem_imm_q[rd_ptr_q]  : hold_imm_q;
  assign ImmType = out_valid ? mem_type_q[rd_ptr_q] : hold_type_q;
  assign count   = count_q;

`ifdef IMM_GEN_PIPE_ILLEGAL_EN
  // ---------------------------------------------------------------------------
  // Per-entry illegal flag and sticky illegal_seen
  // ---------------------------------------------------------------------------
  logic mem_ill_q [DEPTH];
  logic illegal_seen_q, illegal_seen_d;

  always_comb begin
    illegal_seen_d = illegal_seen_q;
    if (push && !type_valid) illegal_seen_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_seen_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_ill_q[i] <= 1'b0;
      end
    end else begin
      illegal_seen_q <= illegal_seen_d;
      if (push) mem_ill_q[wr_ptr_q] <= !type_valid;
    end
  end

  assign illegal      = out_valid && mem_ill_q[rd_ptr_q];
  assign illegal_seen = illegal_seen_q;
`else
  // Without the feature the validity decode is only used to zero the
  // immediate; it is kept as a named signal for readability.
  logic unused_type_valid;
  assign unused_type_valid = type_valid;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Directed bench for imm_gen_pipe. It uses two instances:
//   dut_a: XLEN=32, DEPTH=2, AUTO_DECODE=1
//          (opcode decode, backpressure, flush, async reset)
//   dut_b: XLEN=64, DEPTH=4, AUTO_DECODE=0
//          (ImmSrc mode, 64-bit sign extension, invalid code)
// Expected values are hand-computed constants. A scoreboard queue on dut_a
// records every accepted instruction and checks each popped head against it
// in order.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut_a signals
  logic        a_flush = 1'b0, a_in_valid = 1'b0, a_in_ready, a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [31:0] a_inst = '0;
  logic [2:0]  a_imm_src = '0;
  logic [31:0] a_imm_ext;
  logic [2:0]  a_imm_type;
  logic [1:0]  a_count;

  // dut_b signals
  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_in_ready, b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [31:0] b_inst = '0;
  logic [2:0]  b_imm_src = '0;
  logic [63:0] b_imm_ext;
  logic [2:0]  b_imm_type;
  logic [2:0]  b_count;

`ifdef IMM_GEN_PIPE_ILLEGAL_EN
  logic a_illegal, a_illegal_seen, b_illegal, b_illegal_seen;
`endif

  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .AUTO_DECODE(1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .Inst      (a_inst),
    .ImmSrc    (a_imm_src),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .ImmExt    (a_imm_ext),
    .ImmType   (a_imm_type),
    .count     (a_count)
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
    ,
    .illegal      (a_illegal),
    .illegal_seen (a_illegal_seen)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(4), .AUTO_DECODE(0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .Inst      (b_inst),
    .ImmSrc    (b_imm_src),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .ImmExt    (b_imm_ext),
    .ImmType   (b_imm_type),
    .count     (b_count)
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
    ,
    .illegal      (b_illegal),
    .illegal_seen (b_illegal_seen)
`endif
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for dut_a: {inst, expected imm, expected type}
  // ---------------------------------------------------------------------------
  localparam int NV = 6;
  logic [31:0] vec_inst [NV] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3,
                                 32'h00000033, 32'h123450B7, 32'hFF9FF06F};
  logic [31:0] vec_imm  [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC,
                                 32'h00000000, 32'h12345000, 32'hFFFFFFF8};
  logic [2:0]  vec_type [NV] = '{3'b000, 3'b001, 3'b101, 3'b111, 3'b010, 3'b110};
  localparam int V_I = 0, V_S = 1, V_B = 2, V_BAD = 3, V_U = 4, V_J = 5;

  // ---------------------------------------------------------------------------
  // Scoreboard for dut_a (samples on the falling edge, ahead of the next
  // rising edge at which the transfers occur)
  // ---------------------------------------------------------------------------
  logic [31:0] a_exp_imm  = '0;
  logic [2:0]  a_exp_type = '0;
  logic [34:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (a_flush) begin
        exp_q.delete();
      end else begin
        if (a_out_valid && a_out_ready) begin
          if (exp_q.size() == 0) check("sb_unexpected_pop", {61'd0, a_imm_type}, 64'd0);
          else check("sb_head", {29'd0, a_imm_type, a_imm_ext}, {29'd0, exp_q.pop_front()});
        end
        if (a_in_valid && a_in_ready) exp_q.push_back({a_exp_type, a_exp_imm});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input int v);
    a_in_valid = 1'b1;
    a_inst     = vec_inst[v];
    a_exp_imm  = vec_imm[v];
    a_exp_type = vec_type[v];
  endtask

  task automatic idle_a();
    a_in_valid = 1'b0;
  endtask

  task automatic drive_b(input logic [2:0] src, input logic [31:0] inst);
    b_in_valid = 1'b1;
    b_imm_src  = src;
    b_inst     = inst;
  endtask

  task automatic check_a_head(input string tag, input int v, input int cnt);
    check({tag, "_valid"}, {63'd0, a_out_valid}, 64'd1);
    check({tag, "_imm"},   {32'd0, a_imm_ext},   {32'd0, vec_imm[v]});
    check({tag, "_type"},  {61'd0, a_imm_type},  {61'd0, vec_type[v]});
    check({tag, "_count"}, {62'd0, a_count},     64'(cnt));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check("rst_a_count", {62'd0, a_count}, 64'd0);
    check("rst_a_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("rst_a_in_ready", {63'd0, a_in_ready}, 64'd1);
    check("rst_a_imm", {32'd0, a_imm_ext}, 64'd0);
    check("rst_a_type", {61'd0, a_imm_type}, 64'd0);
    check("rst_b_count", {61'd0, b_count}, 64'd0);
    check("rst_b_imm", b_imm_ext, 64'd0);
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
    check("rst_b_illegal", {63'd0, b_illegal}, 64'd0);
    check("rst_b_illegal_seen", {63'd0, b_illegal_seen}, 64'd0);
`endif

    // Streaming: one instruction per cycle, out_ready held high
    a_out_ready = 1'b1;
    for (int v = 0; v < NV; v++) begin
      drive_a(v);
      step();
      check_a_head($sformatf("stream%0d", v), v, 1);
    end
    idle_a();
    step();
    check("stream_empty_valid", {63'd0, a_out_valid}, 64'd0);
    check("stream_hold_imm", {32'd0, a_imm_ext}, 64'hFFFFFFF8);
    check("stream_hold_type", {61'd0, a_imm_type}, 64'd6);

    // Backpressure: DEPTH=2 fills, third offer is held
    a_out_ready = 1'b0;
    drive_a(V_I); step();
    check("bp_count1", {62'd0, a_count}, 64'd1);
    check("bp_ready1", {63'd0, a_in_ready}, 64'd1);
    drive_a(V_S); step();
    check("bp_count2", {62'd0, a_count}, 64'd2);
    check("bp_ready2", {63'd0, a_in_ready}, 64'd0);
    drive_a(V_B); step();
    check_a_head("bp_held", V_I, 2);
    a_out_ready = 1'b1;
    step();                                  // pop only (full)
    check_a_head("bp_drain1", V_S, 1);
    step();                                  // B pushed, S popped
    check_a_head("bp_drain2", V_B, 1);
    drive_a(V_U); step();                    // simultaneous push/pop at count=1
    check_a_head("bp_pushpop", V_U, 1);
    idle_a(); step();
    check("bp_empty", {62'd0, a_count}, 64'd0);

    // Flush with count=2 and an instruction offered in the same cycle
    a_out_ready = 1'b0;
    drive_a(V_I); step();
    drive_a(V_S); step();
    check("fl_pre_count", {62'd0, a_count}, 64'd2);
    a_flush = 1'b1;
    drive_a(V_J); step();
    a_flush = 1'b0;
    check("fl_count", {62'd0, a_count}, 64'd0);
    check("fl_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("fl_in_ready", {63'd0, a_in_ready}, 64'd1);
    a_out_ready = 1'b1;
    drive_a(V_U); step();
    check_a_head("fl_after", V_U, 1);
    idle_a(); step();
    check("fl_empty", {62'd0, a_count}, 64'd0);

    // Asynchronous reset mid-cycle with count=2
    a_out_ready = 1'b0;
    drive_a(V_B); step();
    drive_a(V_S); step();
    idle_a();
    check("ar_pre_count", {62'd0, a_count}, 64'd2);
    #2 rst = 1'b1;
    #1;
    check("ar_count", {62'd0, a_count}, 64'd0);
    check("ar_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("ar_in_ready", {63'd0, a_in_ready}, 64'd1);
    check("ar_imm", {32'd0, a_imm_ext}, 64'd0);
    check("ar_type", {61'd0, a_imm_type}, 64'd0);
    exp_q.delete();
    #3 rst = 1'b0;
    step();
    a_out_ready = 1'b1;
    drive_a(V_J); step();
    check_a_head("ar_after", V_J, 1);
    idle_a(); step();

    // dut_b: XLEN=64, ImmSrc mode, DEPTH=4
    b_out_ready = 1'b0;
    drive_b(3'b010, 32'h800000B7); step();
    check("b_u_imm", b_imm_ext, 64'hFFFFFFFF80000000);
    check("b_u_type", {61'd0, b_imm_type}, 64'd2);
    check("b_count1", {61'd0, b_count}, 64'd1);
    drive_b(3'b011, 32'hFFFFFFFF); step();
    drive_b(3'b000, 32'h80000093); step();
    check("b_count3", {61'd0, b_count}, 64'd3);
    check("b_ready3", {63'd0, b_in_ready}, 64'd1);
    drive_b(3'b001, 32'hFE112E23); step();
    check("b_count4", {61'd0, b_count}, 64'd4);
    check("b_ready4", {63'd0, b_in_ready}, 64'd0);
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    step();
    check("b_bad_imm", b_imm_ext, 64'd0);
    check("b_bad_type", {61'd0, b_imm_type}, 64'd3);
    check("b_count_d3", {61'd0, b_count}, 64'd3);
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
    check("b_bad_illegal", {63'd0, b_illegal}, 64'd1);
`endif
    step();
    check("b_i_imm", b_imm_ext, 64'hFFFFFFFFFFFFF800);
    check("b_i_type", {61'd0, b_imm_type}, 64'd0);
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
    check("b_i_illegal", {63'd0, b_illegal}, 64'd0);
`endif
    step();
    check("b_s_imm", b_imm_ext, 64'hFFFFFFFFFFFFFFFC);
    check("b_s_type", {61'd0, b_imm_type}, 64'd1);
    step();
    check("b_empty_valid", {63'd0, b_out_valid}, 64'd0);
    check("b_hold_imm", b_imm_ext, 64'hFFFFFFFFFFFFFFFC);
`ifdef IMM_GEN_PIPE_ILLEGAL_EN
    check("b_empty_illegal", {63'd0, b_illegal}, 64'd0);
    check("b_illegal_seen", {63'd0, b_illegal_seen}, 64'd1);
    check("a_illegal_seen", {63'd0, a_illegal_seen}, 64'd0);
`endif

    // Every accepted dut_a instruction must have been popped exactly once
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
